// File: rtl/alu_ram_pkg.sv
// Shared opcode map, region encoding and FSM state type for the ALU/RAM sequencer.
package alu_ram_pkg;

    localparam logic [3:0] OP_RD_ARITH = 4'd0;
    localparam logic [3:0] OP_RD_LOGIC = 4'd1;
    localparam logic [3:0] ARITH_LO    = 4'd4;
    localparam logic [3:0] ARITH_HI    = 4'd7;
    localparam logic [3:0] LOGIC_LO    = 4'd8;
    localparam logic [3:0] LOGIC_HI    = 4'd13;
    localparam logic [3:0] ILLEGAL_LO  = 4'd14;

    localparam logic LOGIC = 1'b0;
    localparam logic ARITH = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op >= ARITH_LO) && (op <= ARITH_HI);
    endfunction

    function automatic logic op_is_logic(input logic [3:0] op);
        return (op >= LOGIC_LO) && (op <= LOGIC_HI);
    endfunction

endpackage

// File: rtl/alu_ram_sched_region_ptr.sv
// Circular-region bookkeeping: write/read pointers plus occupancy, so full and
// empty are told apart by count rather than by pointer equality.
module region_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wp,
    output logic [PTR_W-1:0] rp,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (clr) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign wp    = wp_q;
    assign rp    = rp_q;
    assign count = count_q;
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

endmodule

// File: rtl/alu_ram_sched.sv
// Opcode sequencer between instruction ROM and the ALU/RAM pair; results land in
// two independent circular RAM regions (logic low half, arith high half).
module alu_ram_sched
    import alu_ram_pkg::*;
#(
    parameter int PTR_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           instr_valid,
    input  logic [3:0]     instr,
    output logic           instr_ready,
    output logic [3:0]     sel_op,
    output logic           w_en,
    output logic [PTR_W:0] addr_w,
    output logic           r_en,
    output logic [PTR_W:0] addr_r,
    output logic           rd_valid,
    output logic           rd_region,
    output logic [PTR_W:0] arith_count,
    output logic [PTR_W:0] logic_count,
    output logic           arith_full,
    output logic           arith_empty,
    output logic           logic_full,
    output logic           logic_empty,
    output logic           err_ovf,
    output logic           err_unf,
    output logic           illegal_op
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    state_t state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic [3:0]     sel_op_q, sel_op_d;
    logic           w_en_q, w_en_d;
    logic [PTR_W:0] addr_w_q, addr_w_d;
    logic           r_en_q, r_en_d;
    logic [PTR_W:0] addr_r_q, addr_r_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_region_q, rd_region_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_unf_q, err_unf_d;
    logic           illegal_q, illegal_d;

    logic [PTR_W-1:0] arith_wp, arith_rp, logic_wp, logic_rp;
    logic accept, wr_arith, wr_logic, rd_arith, rd_logic, ovf_now, unf_now;

    // All EXEC-cycle outputs are decided at the accepting edge so they are
    // already registered when EXEC begins; pointers move on the same edge.
    assign accept   = instr_valid && instr_ready;
    assign wr_arith = accept && op_is_arith(instr) && !arith_full;
    assign wr_logic = accept && op_is_logic(instr) && !logic_full;
    assign rd_arith = accept && (instr == OP_RD_ARITH) && !arith_empty;
    assign rd_logic = accept && (instr == OP_RD_LOGIC) && !logic_empty;
    assign ovf_now  = accept && ((op_is_arith(instr) && arith_full) ||
                                 (op_is_logic(instr) && logic_full));
    assign unf_now  = accept && (((instr == OP_RD_ARITH) && arith_empty) ||
                                 ((instr == OP_RD_LOGIC) && logic_empty));

    region_ptr #(.PTR_W(PTR_W)) u_arith (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (wr_arith),
        .pop   (rd_arith),
        .wp    (arith_wp),
        .rp    (arith_rp),
        .count (arith_count),
        .full  (arith_full),
        .empty (arith_empty)
    );

    region_ptr #(.PTR_W(PTR_W)) u_logic (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (wr_logic),
        .pop   (rd_logic),
        .wp    (logic_wp),
        .rp    (logic_rp),
        .count (logic_count),
        .full  (logic_full),
        .empty (logic_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (r_en_q) begin
                    state_d = S_RDWAIT;
                    lat_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (lat_q == LAT_LAST) state_d = S_IDLE;
                else                   lat_d   = lat_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE) && !clr;

        sel_op_d    = sel_op_q;
        w_en_d      = wr_arith || wr_logic;
        addr_w_d    = addr_w_q;
        r_en_d      = rd_arith || rd_logic;
        addr_r_d    = addr_r_q;
        rd_region_d = rd_region_q;
        illegal_d   = accept && (instr >= ILLEGAL_LO);

        if (wr_arith) addr_w_d = {ARITH, arith_wp};
        if (wr_logic) addr_w_d = {LOGIC, logic_wp};
        if (wr_arith || wr_logic) sel_op_d = instr;
        if (rd_arith) begin
            addr_r_d    = {ARITH, arith_rp};
            rd_region_d = ARITH;
        end
        if (rd_logic) begin
            addr_r_d    = {LOGIC, logic_rp};
            rd_region_d = LOGIC;
        end

        // rd_valid is registered, so raise it when entering the last wait cycle.
        rd_valid_d = (state_d == S_RDWAIT) && (lat_d == LAT_LAST);

        err_ovf_d = clr ? 1'b0 : (err_ovf_q || ovf_now);
        err_unf_d = clr ? 1'b0 : (err_unf_q || unf_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_op_q    <= '0;
            w_en_q      <= 1'b0;
            addr_w_q    <= '0;
            r_en_q      <= 1'b0;
            addr_r_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_region_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            sel_op_q    <= sel_op_d;
            w_en_q      <= w_en_d;
            addr_w_q    <= addr_w_d;
            r_en_q      <= r_en_d;
            addr_r_q    <= addr_r_d;
            rd_valid_q  <= rd_valid_d;
            rd_region_q <= rd_region_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign sel_op     = sel_op_q;
    assign w_en       = w_en_q;
    assign addr_w     = addr_w_q;
    assign r_en       = r_en_q;
    assign addr_r     = addr_r_q;
    assign rd_valid   = rd_valid_q;
    assign rd_region  = rd_region_q;
    assign err_ovf    = err_ovf_q;
    assign err_unf    = err_unf_q;
    assign illegal_op = illegal_q;

endmodule
